// File: rtl/mmio_uart_tx_if.sv
// Core data-bus signals that reach the UART transmitter's 16-byte register window.
// The core drives the master side and the peripheral answers on the slave side.
interface mmio_uart_tx_if;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        selected;

    modport master (
        output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
        input  bus_read_data, selected
    );

    modport slave (
        input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
        output bus_read_data, selected
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed from the core's data bus,
// drained by a START/DATA/STOP serialiser. Status reads are combinational.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS = 32'h2000_0000,
    parameter int unsigned CLOCK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    mmio_uart_tx_if.slave bus,
    output logic          uart_tx,
    output logic          tx_empty_irq
);
    localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [15:0]   BIT_LAST = 16'(CLOCK_DIV - 1);
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          enable;
    logic          irq_en;
    logic          overflow;

    logic [1:0]    offset;
    logic          wr_lane0;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          bit_last;
    logic [7:0]    fifo_head;
    logic [15:0]   count_ext;
    logic          unused_bits;

    assign offset       = bus.bus_address[3:2];
    assign bus.selected = (bus.bus_address[31:4] == BASE_ADDRESS[31:4]) &&
                          (bus.bus_read_enable || bus.bus_write_enable);
    assign wr_lane0     = bus.selected && bus.bus_write_enable && bus.bus_byte_enable[0];
    assign push_req     = wr_lane0 && (offset == 2'd0);
    assign full         = (count == DEPTH);
    assign empty        = (count == '0);
    assign bit_last     = (bit_cnt == BIT_LAST);
    assign fifo_head    = mem[rd_ptr];
    assign count_ext    = 16'(count);
    assign unused_bits  = ^{bus.bus_address[1:0], bus.bus_write_data[31:8], bus.bus_byte_enable[3:1]};

    // Pops happen only at frame boundaries, so clearing enable lets the current frame finish.
    assign pop  = enable && !empty && ((state == IDLE) || ((state == STOP) && bit_last));
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push = push_req && (!full || pop);

    always_comb begin
        bus.bus_read_data = '0;
        if (bus.selected && bus.bus_read_enable) begin
            case (offset)
                2'd1:    bus.bus_read_data = {16'h0, count_ext[7:0], 4'h0, overflow, empty, full, state != IDLE};
                2'd2:    bus.bus_read_data = {30'h0, irq_en, enable};
                default: bus.bus_read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.bus_write_data[7:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (wr_lane0 && (offset == 2'd1) && bus.bus_write_data[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable       <= 1'b1;
            irq_en       <= 1'b0;
            tx_empty_irq <= 1'b0;
        end else begin
            if (wr_lane0 && (offset == 2'd2)) begin
                enable <= bus.bus_write_data[0];
                irq_en <= bus.bus_write_data[1];
            end
            tx_empty_irq <= empty && (state == IDLE) && irq_en;
        end
    end

    // uart_tx is registered alongside the state so the line changes on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    bit_cnt <= '0;
                    if (pop) begin
                        shift   <= fifo_head;
                        state   <= START;
                        uart_tx <= 1'b0;
                    end
                end
                START: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        uart_tx <= shift[0];
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift   <= fifo_head;
                            state   <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: drives the bus interface, keeps a byte-queue model of
// what must appear on the line and compares each 8N1 frame cycle by cycle.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * DIV;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic uart_tx;
    logic tx_empty_irq;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mq[$];

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_ADDRESS(BASE), .CLOCK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .uart_tx(uart_tx), .tx_empty_irq(tx_empty_irq)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] status_word(input logic busy, input int cnt, input logic ovf);
        return {16'h0, 8'(cnt), 4'h0, ovf, cnt == 0, cnt == DEPTH, busy};
    endfunction

    task automatic bus_idle();
        bus.bus_address      = '0;
        bus.bus_write_data   = '0;
        bus.bus_byte_enable  = '0;
        bus.bus_read_enable  = 1'b0;
        bus.bus_write_enable = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clock);
        bus.bus_address      = addr;
        bus.bus_write_data   = data;
        bus.bus_byte_enable  = be;
        bus.bus_write_enable = 1'b1;
        @(posedge clock);
        #1;
        bus.bus_write_enable = 1'b0;
        bus.bus_byte_enable  = '0;
    endtask

    // Leaves the caller at a sample point inside the cycle that was read.
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clock);
        bus.bus_address     = addr;
        bus.bus_read_enable = 1'b1;
        #1;
        data = bus.bus_read_data;
        bus.bus_read_enable = 1'b0;
    endtask

    // Called at a sample point; returns at the sample point of the cycle after the frame.
    task automatic expect_frame(input string name, input int max_wait, input bit chk_busy);
        logic [7:0]  b;
        logic [31:0] st = 32'h1;
        logic        lvl;
        logic        bad_tx = 1'b0;
        int          w = 0;
        int          bad_k = -1;
        checks++;
        if (mq.size() == 0) begin
            errors++;
            $display("FAIL %s: frame expected but model queue is empty", name);
            return;
        end
        b = mq.pop_front();
        while (uart_tx !== 1'b0 && w < max_wait) begin
            @(negedge clock);
            w++;
        end
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL %s: start bit missing after %0d cycles, tx=%b required 0", name, w, uart_tx);
            @(negedge clock);
            return;
        end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clock);
            lvl = (k < DIV) ? 1'b0 : (k < 9 * DIV) ? b[(k - DIV) / DIV] : 1'b1;
            if (chk_busy) begin
                bus.bus_address     = BASE + 32'h4;
                bus.bus_read_enable = 1'b1;
                #1;
                st = bus.bus_read_data;
                bus.bus_read_enable = 1'b0;
            end
            if (bad_k < 0 && (uart_tx !== lvl || st[0] !== 1'b1)) begin
                bad_k  = k;
                bad_tx = uart_tx;
            end
        end
        if (bad_k >= 0) begin
            errors++;
            $display("FAIL %s: byte %h cycle %0d tx=%b busy=%b required tx per 8N1, busy=1",
                     name, b, bad_k, bad_tx, st[0]);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_idle();
        mq.delete();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (uart_tx !== 1'b1 || tx_empty_irq !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: tx=%b irq=%b required tx=1 irq=0", uart_tx, tx_empty_irq);
        end
        reset_n = 1'b1;
        bus.bus_address = BASE + 32'h4;
        #1;
        checks++;
        if (bus.selected !== 1'b0 || bus.bus_read_data !== 32'h0) begin
            errors++; $display("FAIL no_strobe: sel=%b rdata=%h required 0/0", bus.selected, bus.bus_read_data);
        end
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h required %h", d, 32'h4); end
        bus.bus_read_enable = 1'b1;
        #1;
        checks++;
        if (bus.selected !== 1'b1) begin errors++; $display("FAIL selected: got %b required 1", bus.selected); end
        bus.bus_read_enable = 1'b0;
        bus_read(BASE + 32'h8, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h required %h", d, 32'h1); end
        bus_read(BASE, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h required 0", d); end
        bus_read(BASE + 32'hC, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h required 0", d); end
        bus.bus_address     = BASE + 32'h14;
        bus.bus_read_enable = 1'b1;
        #1;
        checks++;
        if (bus.selected !== 1'b0 || bus.bus_read_data !== 32'h0) begin
            errors++; $display("FAIL out_of_window: sel=%b rdata=%h required 0/0", bus.selected, bus.bus_read_data);
        end
        bus.bus_read_enable = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        mq.push_back(8'hA5);
        bus_write(BASE, 32'hFFFF_FFA5, 4'h1);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== status_word(1'b0, 1, 1'b0) || uart_tx !== 1'b1) begin
            errors++; $display("FAIL write_latency: status=%h tx=%b required %h tx=1", d, uart_tx, status_word(1'b0, 1, 1'b0));
        end
        @(negedge clock);
        expect_frame("frame_a5", 0, 1'b1);
        bus.bus_address     = BASE + 32'h4;
        bus.bus_read_enable = 1'b1;
        #1;
        checks++;
        if (bus.bus_read_data !== 32'h4 || uart_tx !== 1'b1) begin
            errors++; $display("FAIL after_a5: status=%h tx=%b required 00000004 tx=1", bus.bus_read_data, uart_tx);
        end
        bus.bus_read_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        mq.push_back(8'h11);
        mq.push_back(8'h22);
        bus_write(BASE, 32'h11, 4'h1);
        bus_write(BASE, 32'h22, 4'h1);
        @(negedge clock);
        expect_frame("b2b_first", 0, 1'b1);
        expect_frame("b2b_second", 0, 1'b1);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL b2b_end: tx=%b required 1", uart_tx); end
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL b2b_status: got %h required 00000004", d); end
    endtask

    task automatic test_random_stream();
        logic [31:0] addr [7];
        logic [31:0] data [7];
        logic [3:0]  be   [7];
        logic [31:0] d;
        int n = $urandom_range(3, 7);
        int nvalid = 0;
        for (int i = 0; i < n; i++) begin
            int kind = (i == 0) ? 0 : int'($urandom_range(0, 3));
            data[i] = $urandom;
            case (kind)
                0: begin addr[i] = BASE;                                      be[i] = 4'(($urandom & 32'hE) | 32'h1); end
                1: begin addr[i] = BASE;                                      be[i] = 4'($urandom & 32'hE); end
                2: begin addr[i] = BASE + 32'h10 * $urandom_range(1, 4);      be[i] = 4'hF; end
                default: begin addr[i] = BASE + 32'hC;                        be[i] = 4'h1; end
            endcase
            if (addr[i][31:4] == BASE[31:4] && addr[i][3:2] == 2'd0 && be[i][0]) begin
                mq.push_back(data[i][7:0]);
                nvalid++;
            end
        end
        @(negedge clock);
        fork
            for (int i = 0; i < nvalid; i++) expect_frame("rand_stream", (i == 0) ? 6 : 0, 1'b0);
            for (int j = 0; j < n; j++) bus_write(addr[j], data[j], be[j]);
        join
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h4 || mq.size() != 0) begin
            errors++; $display("FAIL rand_idle: status=%h left=%0d required 00000004 left=0", d, mq.size());
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  b;
        bus_write(BASE + 32'h8, 32'h0, 4'h1);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            bus_write(BASE, {24'h0, b}, 4'h1);
            if (i < DEPTH) mq.push_back(b);
        end
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== status_word(1'b0, 8, 1'b1) || uart_tx !== 1'b1) begin
            errors++; $display("FAIL overflow_set: status=%h tx=%b required %h tx=1", d, uart_tx, status_word(1'b0, 8, 1'b1));
        end
        bus_write(BASE + 32'h4, 32'h8, 4'h2);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== status_word(1'b0, 8, 1'b1)) begin
            errors++; $display("FAIL ovf_no_lane0: got %h required %h", d, status_word(1'b0, 8, 1'b1));
        end
        bus_write(BASE + 32'h4, 32'h8, 4'h1);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== status_word(1'b0, 8, 1'b0)) begin
            errors++; $display("FAIL ovf_clear: got %h required %h", d, status_word(1'b0, 8, 1'b0));
        end
        bus_write(BASE, 32'h5A, 4'hE);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== status_word(1'b0, 8, 1'b0)) begin
            errors++; $display("FAIL full_be_clear: got %h required %h", d, status_word(1'b0, 8, 1'b0));
        end
        // The write right after enabling lands in the cycle of the first pop.
        b = 8'($urandom);
        mq.push_back(b);
        bus_write(BASE + 32'h8, 32'h1, 4'h1);
        bus_write(BASE, {24'h0, b}, 4'h1);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== status_word(1'b1, 8, 1'b0)) begin
            errors++; $display("FAIL push_pop_full: got %h required %h", d, status_word(1'b1, 8, 1'b0));
        end
        for (int i = 0; i < 9; i++) expect_frame("drain", 0, 1'b0);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL drain_status: got %h required 00000004", d); end
    endtask

    task automatic test_enable_mid_frame();
        logic [31:0] d;
        logic [7:0]  b0 = 8'($urandom);
        logic [7:0]  b1 = 8'($urandom);
        mq.push_back(b0);
        mq.push_back(b1);
        bus_write(BASE, {24'h0, b0}, 4'h1);
        bus_write(BASE, {24'h0, b1}, 4'h1);
        @(negedge clock);
        fork
            expect_frame("disable_frame", 0, 1'b0);
            begin repeat (10) @(negedge clock); bus_write(BASE + 32'h8, 32'h0, 4'h1); end
        join
        repeat (8) @(negedge clock);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== status_word(1'b0, 1, 1'b0) || uart_tx !== 1'b1) begin
            errors++; $display("FAIL disabled_idle: status=%h tx=%b required %h tx=1", d, uart_tx, status_word(1'b0, 1, 1'b0));
        end
        bus_write(BASE + 32'h8, 32'h1, 4'h1);
        @(negedge clock);
        fork
            expect_frame("reenable_frame", 2, 1'b0);
            begin repeat (20) @(negedge clock); bus_write(BASE + 32'h8, 32'h3, 4'h1); end
        join
        checks++;
        if (tx_empty_irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b required 0", tx_empty_irq); end
        @(negedge clock);
        checks++;
        if (tx_empty_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b required 1", tx_empty_irq); end
        bus_read(BASE + 32'h8, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL ctrl_readback: got %h required 00000003", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0]  b = 8'($urandom) & 8'hFD;
        bus_write(BASE, {24'h0, b}, 4'h1);
        bus_write(BASE, $urandom, 4'h1);
        @(negedge clock);
        repeat (2 * DIV + 1) @(negedge clock);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL pre_reset_bit: tx=%b required 0", uart_tx); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || tx_empty_irq !== 1'b0) begin
            errors++; $display("FAIL async_reset: tx=%b irq=%b required tx=1 irq=0", uart_tx, tx_empty_irq);
        end
        @(negedge clock);
        reset_n = 1'b1;
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL post_reset_status: got %h required 00000004", d); end
        repeat (2 * FRAME) @(negedge clock);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h4 || uart_tx !== 1'b1) begin
            errors++; $display("FAIL data_lost: status=%h tx=%b required 00000004 tx=1", d, uart_tx);
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_stream();
        test_overflow();
        test_enable_mid_frame();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
